fp_issue_to_regread_pipe_reg: RTL and testbench
===============================================

Name: fp_issue_to_regread_pipe_reg

Overview:
- Per-lane pipeline register between the FP issue stage and the FP register-read stage.
- Captures the issued FP micro-ops, holds them under stall, and kills them on full flush or selective recovery.
- Selective recovery uses an active-list pointer age comparison that handles pointer wrap-around.
- Also keeps a saturating count of killed ops for performance counters.

Parameters:
- FP_ISSUE_WIDTH, 2, number of FP issue lanes.
- PAYLOAD_WIDTH, 64, opaque per-lane op payload in bits (opcode, tags, immediates).
- AL_INDEX_WIDTH, 6, active-list index width; each pointer carries one extra wrap bit.
- KILL_CNT_WIDTH, 16, width of the killed-op counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  register-read stage cannot accept; hold the current contents.
- clear  in  1  full pipeline flush.
- recover  in  1  selective flush request.
- recover_ptr  in  AL_INDEX_WIDTH+1  oldest active-list pointer to kill, as {wrap, index}.
- in_valid  in  FP_ISSUE_WIDTH  per-lane valid from the issue stage.
- in_payload  in  FP_ISSUE_WIDTH*PAYLOAD_WIDTH  per-lane payload; lane i occupies bits [i*PW +: PW].
- in_al_ptr  in  FP_ISSUE_WIDTH*(AL_INDEX_WIDTH+1)  per-lane active-list pointer.
- out_valid  out  FP_ISSUE_WIDTH  registered valid to register-read.
- out_payload  out  FP_ISSUE_WIDTH*PAYLOAD_WIDTH  registered payload.
- out_al_ptr  out  FP_ISSUE_WIDTH*(AL_INDEX_WIDTH+1)  registered pointer.
- kill_count  out  KILL_CNT_WIDTH  saturating count of ops killed by clear or recover.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_payload=0, out_al_ptr=0, kill_count=0. Reset asserted mid-stall or mid-recover drops everything immediately.
- Latency: 1 cycle from in_* to out_*. All outputs are driven directly from flops.
- Candidate set each cycle:
  - stall=1: the held entries.
  - stall=0: the incoming entries.
- Priority each cycle: clear > recover > stall/load.
- clear=1:
  - All out_valid go to 0 next cycle. Payload and pointer flops may hold any value.
  - kill_count += popcount(valid bits of the candidate set).
- recover=1, clear=0:
  - Each valid candidate lane whose pointer is younger-or-equal to recover_ptr is loaded or held with valid=0.
  - All other candidate lanes are loaded or held unchanged.
  - kill_count += number of lanes killed.
- Age rule, for entry pointer p versus recover_ptr r:
  - Same wrap bit: kill iff p.index >= r.index.
  - Different wrap bit: kill iff p.index < r.index.
  - p == r is killed.
- Neither clear nor recover:
  - stall=1: all flops hold.
  - stall=0: every lane loads in_valid/in_payload/in_al_ptr, including invalid lanes, whose valid loads as 0.
- Invalid lanes never increment kill_count.
- kill_count saturates at all-ones and never wraps.
- Lanes are independent. A mix of killed and surviving lanes in one cycle is legal.
- No backpressure output: the issue stage receives the same stall signal externally.

Decomposition:
- Shared package holds:
  - the AL pointer struct {wrap, index} and its width constant;
  - FP_ISSUE_WIDTH;
  - a pure function is_younger_or_equal(p, r) implementing the age rule, reused by other recovery logic.
- One natural sub-module: fp_pipe_reg_lane (a single lane's valid/payload/pointer flops with kill and hold), instantiated FP_ISSUE_WIDTH times.
- The top level adds the kill popcount and the saturating counter.

Test Plan:
- Reset then load: rst pulse; in_valid=2'b11, al_ptr lane0=0x05, lane1=0x06, stall=0 -> next cycle out_valid=2'b11 with matching ptrs/payloads; kill_count=0.
- Stall hold: load lane0 payload 0xA5A5; then stall=1 for 3 cycles while in_payload changes -> out_payload stays 0xA5A5 and out_valid stays 1 throughout.
- Selective recover without stall: in_al_ptr lane0=0x03, lane1=0x04; recover=1, recover_ptr=0x04 -> out_valid=2'b01, kill_count=1.
- Wrap-around recover during stall: held ptrs lane0=0x7E (wrap=1, idx=62), lane1=0x01 (wrap=0, idx=1); recover_ptr=0x7F (wrap=1, idx=63) -> lane1 killed, lane0 kept; out_valid=2'b01.
- Clear overrides stall and recover: held out_valid=2'b11; clear=1, recover=1, stall=1 -> out_valid=2'b00, kill_count increases by exactly 2.
- Counter saturation: kill_count forced near 16'hFFFE by repeated clears of two valid lanes -> it reaches 16'hFFFF and stays there on further clears; async rst mid-run returns it to 0 without a clock edge.

Source files
------------

// File: rtl/fp_issue_to_regread_pipe_reg_pkg.sv
// Shared types and helpers for the FP issue-to-register-read pipeline register.
// The age comparison is shared with other recovery logic, so it lives here.
package fp_issue_to_regread_pipe_reg_pkg;

  localparam int FP_ISSUE_WIDTH = 2;
  localparam int AL_INDEX_WIDTH = 6;
  localparam int AL_PTR_WIDTH   = AL_INDEX_WIDTH + 1;

  typedef struct packed {
    logic                      wrap;
    logic [AL_INDEX_WIDTH-1:0] index;
  } al_ptr_t;

  // True when p is the same age as r or younger; the wrap bit disambiguates wrap-around.
  function automatic logic is_younger_or_equal(al_ptr_t p, al_ptr_t r);
    logic res;
    if (p.wrap == r.wrap) begin
      res = (p.index >= r.index);
    end else begin
      res = (p.index < r.index);
    end
    return res;
  endfunction

endpackage

// File: rtl/fp_issue_to_regread_pipe_reg_lane.sv
// One lane of the FP issue-to-register-read register: valid, payload and
// active-list pointer flops with hold, full flush and selective kill.
module fp_pipe_reg_lane
  import fp_issue_to_regread_pipe_reg_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     clear,
  input  logic                     recover,
  input  logic [AL_PTR_WIDTH-1:0]  recover_ptr,
  input  logic                     in_valid,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  input  logic [AL_PTR_WIDTH-1:0]  in_al_ptr,
  output logic                     out_valid,
  output logic [PAYLOAD_WIDTH-1:0] out_payload,
  output logic [AL_PTR_WIDTH-1:0]  out_al_ptr,
  output logic                     killed
);

  logic                     valid_q;
  logic                     valid_d;
  logic [PAYLOAD_WIDTH-1:0] payload_q;
  logic [PAYLOAD_WIDTH-1:0] payload_d;
  logic [AL_PTR_WIDTH-1:0]  ptr_q;
  logic [AL_PTR_WIDTH-1:0]  ptr_d;

  logic                     cand_valid_s;
  logic [PAYLOAD_WIDTH-1:0] cand_payload_s;
  logic [AL_PTR_WIDTH-1:0]  cand_ptr_s;
  logic                     kill_s;

  // Candidate selection (held vs incoming), kill decision and next state.
  always_comb begin
    cand_valid_s   = valid_q;
    cand_payload_s = payload_q;
    cand_ptr_s     = ptr_q;
    kill_s         = 1'b0;
    if (!stall) begin
      cand_valid_s   = in_valid;
      cand_payload_s = in_payload;
      cand_ptr_s     = in_al_ptr;
    end else begin
      cand_valid_s   = valid_q;
      cand_payload_s = payload_q;
      cand_ptr_s     = ptr_q;
    end

    // Only a valid candidate can be killed, so invalid lanes never count.
    if (clear) begin
      kill_s = cand_valid_s;
    end else if (recover) begin
      kill_s = cand_valid_s &
               is_younger_or_equal(al_ptr_t'(cand_ptr_s), al_ptr_t'(recover_ptr));
    end else begin
      kill_s = 1'b0;
    end

    valid_d   = cand_valid_s & ~kill_s;
    payload_d = cand_payload_s;
    ptr_d     = cand_ptr_s;
  end

  // Lane state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= {PAYLOAD_WIDTH{1'b0}};
      ptr_q     <= {AL_PTR_WIDTH{1'b0}};
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      ptr_q     <= ptr_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_payload = payload_q;
  assign out_al_ptr  = ptr_q;
  assign killed      = kill_s;

endmodule

// File: rtl/fp_issue_to_regread_pipe_reg.sv
// Per-lane pipeline register between FP issue and FP register read, with
// a saturating count of ops killed by clear or selective recovery.
module fp_issue_to_regread_pipe_reg #(
  parameter int FP_ISSUE_WIDTH = fp_issue_to_regread_pipe_reg_pkg::FP_ISSUE_WIDTH,
  parameter int PAYLOAD_WIDTH  = 64,
  parameter int AL_INDEX_WIDTH = fp_issue_to_regread_pipe_reg_pkg::AL_INDEX_WIDTH,
  parameter int KILL_CNT_WIDTH = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     stall,
  input  logic                                     clear,
  input  logic                                     recover,
  input  logic [AL_INDEX_WIDTH:0]                  recover_ptr,
  input  logic [FP_ISSUE_WIDTH-1:0]                in_valid,
  input  logic [FP_ISSUE_WIDTH*PAYLOAD_WIDTH-1:0]  in_payload,
  input  logic [FP_ISSUE_WIDTH*(AL_INDEX_WIDTH+1)-1:0] in_al_ptr,
  output logic [FP_ISSUE_WIDTH-1:0]                out_valid,
  output logic [FP_ISSUE_WIDTH*PAYLOAD_WIDTH-1:0]  out_payload,
  output logic [FP_ISSUE_WIDTH*(AL_INDEX_WIDTH+1)-1:0] out_al_ptr,
  output logic [KILL_CNT_WIDTH-1:0]                kill_count
);

  import fp_issue_to_regread_pipe_reg_pkg::*;

  localparam int PW = PAYLOAD_WIDTH;
  localparam int AW = AL_INDEX_WIDTH + 1;

  logic [FP_ISSUE_WIDTH-1:0] lane_kill_s;
  logic [KILL_CNT_WIDTH:0]   kill_sum_s;
  logic [KILL_CNT_WIDTH-1:0] kill_cnt_q;
  logic [KILL_CNT_WIDTH-1:0] kill_cnt_d;

  for (genvar i = 0; i < FP_ISSUE_WIDTH; i++) begin : g_lane
    fp_pipe_reg_lane #(
      .PAYLOAD_WIDTH (PW)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .clear       (clear),
      .recover     (recover),
      .recover_ptr (recover_ptr),
      .in_valid    (in_valid[i]),
      .in_payload  (in_payload[i*PW +: PW]),
      .in_al_ptr   (in_al_ptr[i*AW +: AW]),
      .out_valid   (out_valid[i]),
      .out_payload (out_payload[i*PW +: PW]),
      .out_al_ptr  (out_al_ptr[i*AW +: AW]),
      .killed      (lane_kill_s[i])
    );
  end

  // Add this cycle's kills with one spare bit so overflow can be clamped.
  always_comb begin
    kill_sum_s = {1'b0, kill_cnt_q};
    for (int i = 0; i < FP_ISSUE_WIDTH; i++) begin
      kill_sum_s = kill_sum_s + {{KILL_CNT_WIDTH{1'b0}}, lane_kill_s[i]};
    end
    if (kill_sum_s[KILL_CNT_WIDTH]) begin
      kill_cnt_d = {KILL_CNT_WIDTH{1'b1}};
    end else begin
      kill_cnt_d = kill_sum_s[KILL_CNT_WIDTH-1:0];
    end
  end

  // Kill counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kill_cnt_q <= {KILL_CNT_WIDTH{1'b0}};
    end else begin
      kill_cnt_q <= kill_cnt_d;
    end
  end

  assign kill_count = kill_cnt_q;

endmodule

// File: tb/tb_fp_issue_to_regread_pipe_reg.sv
// Directed, scoreboard-checked bench for fp_issue_to_regread_pipe_reg.
module tb_fp_issue_to_regread_pipe_reg;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall;
  logic         clear;
  logic         recover;
  logic [6:0]   recover_ptr;
  logic [1:0]   in_valid;
  logic [127:0] in_payload;
  logic [13:0]  in_al_ptr;
  logic [1:0]   out_valid;
  logic [127:0] out_payload;
  logic [13:0]  out_al_ptr;
  logic [15:0]  kill_count;

  typedef struct {
    logic [1:0]  valid;
    logic [63:0] pl0;
    logic [63:0] pl1;
    logic [6:0]  p0;
    logic [6:0]  p1;
    logic [15:0] kc;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   nchecks = 0;
  int   nerr    = 0;
  int   step_id = 0;

  fp_issue_to_regread_pipe_reg dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .clear       (clear),
    .recover     (recover),
    .recover_ptr (recover_ptr),
    .in_valid    (in_valid),
    .in_payload  (in_payload),
    .in_al_ptr   (in_al_ptr),
    .out_valid   (out_valid),
    .out_payload (out_payload),
    .out_al_ptr  (out_al_ptr),
    .kill_count  (kill_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int id, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s (step %0d): observed %h expected %h", tag, id, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [63:0] pl0, input logic [63:0] pl1,
                       input logic [6:0] p0, input logic [6:0] p1, input logic st,
                       input logic cl, input logic rc, input logic [6:0] rp);
    in_valid    = v;
    in_payload  = {pl1, pl0};
    in_al_ptr   = {p1, p0};
    stall       = st;
    clear       = cl;
    recover     = rc;
    recover_ptr = rp;
  endtask

  // Push the expected post-edge state, clock once, then pop and compare.
  task automatic expect_step(input logic [1:0] v, input logic [63:0] pl0, input logic [63:0] pl1,
                             input logic [6:0] p0, input logic [6:0] p1, input logic [15:0] kc);
    exp_t e;
    step_id++;
    e.valid = v; e.pl0 = pl0; e.pl1 = pl1; e.p0 = p0; e.p1 = p1; e.kc = kc; e.id = step_id;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("out_valid", e.id, {62'd0, out_valid}, {62'd0, e.valid});
    check("kill_count", e.id, {48'd0, kill_count}, {48'd0, e.kc});
    if (e.valid[0]) begin
      check("payload0", e.id, out_payload[63:0], e.pl0);
      check("al_ptr0", e.id, {57'd0, out_al_ptr[6:0]}, {57'd0, e.p0});
    end
    if (e.valid[1]) begin
      check("payload1", e.id, out_payload[127:64], e.pl1);
      check("al_ptr1", e.id, {57'd0, out_al_ptr[13:7]}, {57'd0, e.p1});
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".valid"}, 0, {62'd0, out_valid}, 64'd0);
    check({tag, ".payload_lo"}, 0, out_payload[63:0], 64'd0);
    check({tag, ".payload_hi"}, 0, out_payload[127:64], 64'd0);
    check({tag, ".al_ptr"}, 0, {50'd0, out_al_ptr}, 64'd0);
    check({tag, ".kill_count"}, 0, {48'd0, kill_count}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b00, 64'd0, 64'd0, 7'h00, 7'h00, 1'b0, 1'b0, 1'b0, 7'h00);
    #12;
    check_reset_state("reset");
    rst = 1'b0;

    // Reset then load both lanes.
    drive(2'b11, 64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002, 7'h05, 7'h06, 1'b0, 1'b0, 1'b0, 7'h00);
    expect_step(2'b11, 64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002, 7'h05, 7'h06, 16'd0);

    // Stall hold: lane0 keeps A5A5 while inputs change.
    drive(2'b01, 64'h0000_0000_0000_A5A5, 64'h3333_0000_0000_0003, 7'h10, 7'h11, 1'b0, 1'b0, 1'b0, 7'h00);
    expect_step(2'b01, 64'h0000_0000_0000_A5A5, 64'd0, 7'h10, 7'h00, 16'd0);
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, {$urandom, $urandom}, {$urandom, $urandom}, 7'h2A, 7'h2B, 1'b1, 1'b0, 1'b0, 7'h00);
      expect_step(2'b01, 64'h0000_0000_0000_A5A5, 64'd0, 7'h10, 7'h00, 16'd0);
    end

    // Selective recover without stall; lane1 pointer equals recover_ptr.
    drive(2'b11, 64'h4444_0000_0000_0004, 64'h5555_0000_0000_0005, 7'h03, 7'h04, 1'b0, 1'b0, 1'b1, 7'h04);
    expect_step(2'b01, 64'h4444_0000_0000_0004, 64'd0, 7'h03, 7'h00, 16'd1);

    // Wrap-around recover while stalled: held 0x7E survives, held 0x01 dies.
    drive(2'b11, 64'h6666_0000_0000_0006, 64'h7777_0000_0000_0007, 7'h7E, 7'h01, 1'b0, 1'b0, 1'b0, 7'h00);
    expect_step(2'b11, 64'h6666_0000_0000_0006, 64'h7777_0000_0000_0007, 7'h7E, 7'h01, 16'd1);
    drive(2'b11, 64'h8888_0000_0000_0008, 64'h9999_0000_0000_0009, 7'h7F, 7'h7E, 1'b1, 1'b0, 1'b1, 7'h7F);
    expect_step(2'b01, 64'h6666_0000_0000_0006, 64'd0, 7'h7E, 7'h00, 16'd2);
    drive(2'b11, 64'h8888_0000_0000_0008, 64'h9999_0000_0000_0009, 7'h7F, 7'h7E, 1'b1, 1'b0, 1'b0, 7'h00);
    expect_step(2'b01, 64'h6666_0000_0000_0006, 64'd0, 7'h7E, 7'h00, 16'd2);

    // Clear overrides stall and recover.
    drive(2'b11, 64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B, 7'h20, 7'h21, 1'b0, 1'b0, 1'b0, 7'h00);
    expect_step(2'b11, 64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B, 7'h20, 7'h21, 16'd2);
    drive(2'b00, 64'd0, 64'd0, 7'h00, 7'h00, 1'b1, 1'b1, 1'b1, 7'h7F);
    expect_step(2'b00, 64'd0, 64'd0, 7'h00, 7'h00, 16'd4);

    // Invalid lanes are never counted, by recover or by clear.
    drive(2'b10, 64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D, 7'h30, 7'h31, 1'b0, 1'b0, 1'b1, 7'h00);
    expect_step(2'b00, 64'd0, 64'd0, 7'h00, 7'h00, 16'd5);
    drive(2'b01, 64'hEEEE_0000_0000_000E, 64'hFFFF_0000_0000_000F, 7'h32, 7'h33, 1'b0, 1'b1, 1'b0, 7'h00);
    expect_step(2'b00, 64'd0, 64'd0, 7'h00, 7'h00, 16'd6);

    // Mixed recover: lane0 younger (killed), lane1 older (survives).
    drive(2'b11, 64'h1234_0000_0000_0010, 64'h5678_0000_0000_0011, 7'h45, 7'h43, 1'b0, 1'b0, 1'b1, 7'h44);
    expect_step(2'b10, 64'd0, 64'h5678_0000_0000_0011, 7'h00, 7'h43, 16'd7);

    // Async reset between clock edges clears everything.
    drive(2'b11, 64'h0F0F_0000_0000_0012, 64'hF0F0_0000_0000_0013, 7'h40, 7'h41, 1'b0, 1'b0, 1'b0, 7'h00);
    expect_step(2'b11, 64'h0F0F_0000_0000_0012, 64'hF0F0_0000_0000_0013, 7'h40, 7'h41, 16'd7);
    #3;
    rst = 1'b1;
    #1;
    check_reset_state("async_reset_mid");
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Saturation: 32767 clears of two valid lanes gives 16'hFFFE.
    drive(2'b11, 64'd1, 64'd2, 7'h01, 7'h02, 1'b0, 1'b1, 1'b0, 7'h00);
    for (int i = 0; i < 32767; i++) begin
      @(posedge clk);
    end
    #1;
    check("kill_count_fffe", 0, {48'd0, kill_count}, {48'd0, 16'hFFFE});
    expect_step(2'b00, 64'd0, 64'd0, 7'h00, 7'h00, 16'hFFFF);
    expect_step(2'b00, 64'd0, 64'd0, 7'h00, 7'h00, 16'hFFFF);
    drive(2'b01, 64'd1, 64'd2, 7'h01, 7'h02, 1'b0, 1'b1, 1'b0, 7'h00);
    expect_step(2'b00, 64'd0, 64'd0, 7'h00, 7'h00, 16'hFFFF);

    // Async reset mid-stall/mid-recover, no clock edge needed.
    drive(2'b11, 64'd3, 64'd4, 7'h05, 7'h06, 1'b1, 1'b0, 1'b1, 7'h00);
    #3;
    rst = 1'b1;
    #1;
    check_reset_state("async_reset_saturated");
    #1;
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
